// File: rtl/mul_pkg.sv
// ============================================================================
// Module  : mul_pkg
// Purpose : Shared types and sizing for the sequential Booth multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  localparam int N_DEF = 6;
  localparam int CNT_W = $clog2(N_DEF + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_Q = 3'd1,
    CALC   = 3'd2,
    LOAD_R = 3'd3,
    ADD    = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/booth_multiplier_step.sv
// ============================================================================
// Module  : booth_step
// Purpose : One radix-2 Booth iteration: add/sub of M, then arithmetic shift
//           of {A,Q,q_m1}. Purely combinational.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_step #(
  parameter int N = 6
) (
  input  logic [N:0]   i_a,
  input  logic [N-1:0] i_q,
  input  logic         i_qm1,
  input  logic [N-1:0] i_m,
  output logic [N:0]   o_a,
  output logic [N-1:0] o_q,
  output logic         o_qm1
);

  logic [N:0] w_m_ext;
  logic [N:0] w_sum;

  always_comb begin
    w_m_ext = {i_m[N-1], i_m};
    case ({i_q[0], i_qm1})
      2'b10:   w_sum = i_a - w_m_ext;
      2'b01:   w_sum = i_a + w_m_ext;
      default: w_sum = i_a;
    endcase
    // Shift replicates the extra sign bit, so A stays a valid N+1-bit value.
    o_a   = {w_sum[N], w_sum[N:1]};
    o_q   = {w_sum[0], i_q[N-1:1]};
    o_qm1 = i_q[0];
  end

endmodule

`default_nettype wire

// File: rtl/booth_multiplier.sv
// ============================================================================
// Module  : booth_multiplier
// Purpose : Sequential signed radix-2 Booth multiplier on the shared N-bit
//           operand bus. Optional macro MUL_ACC_EN adds a final +R stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_multiplier
  import mul_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] inBus,
  input  logic         output_sel,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] outBus
);

  localparam int CW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [N-1:0]    m_q, m_d;
  logic [N:0]      a_q, a_d;
  logic [N-1:0]    q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;

  logic [N:0]      w_step_a;
  logic [N-1:0]    w_step_q;
  logic            w_step_qm1;

`ifdef MUL_ACC_EN
  logic [N-1:0]    r_q, r_d;
  logic [2*N-1:0]  w_acc;
  assign w_acc = {a_q[N-1:0], q_q} + {{N{r_q[N-1]}}, r_q};
`endif

  booth_step #(.N(N)) u_step (
    .i_a   (a_q),
    .i_q   (q_q),
    .i_qm1 (qm1_q),
    .i_m   (m_q),
    .o_a   (w_step_a),
    .o_q   (w_step_q),
    .o_qm1 (w_step_qm1)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
`ifdef MUL_ACC_EN
    r_d     = r_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = inBus;
          done_d  = 1'b0;
          state_d = LOAD_Q;
        end
      end
      LOAD_Q: begin
        q_d     = inBus;
        a_d     = '0;
        qm1_d   = 1'b0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        a_d   = w_step_a;
        q_d   = w_step_q;
        qm1_d = w_step_qm1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
`ifdef MUL_ACC_EN
          state_d = LOAD_R;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef MUL_ACC_EN
      LOAD_R: begin
        r_d     = inBus;
        state_d = ADD;
      end
      ADD: begin
        // Keep A's extra bit consistent with the wrapped 2N-bit sum.
        a_d     = {w_acc[2*N-1], w_acc[2*N-1:N]};
        q_d     = w_acc[N-1:0];
        done_d  = 1'b1;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef MUL_ACC_EN
      r_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef MUL_ACC_EN
      r_q     <= r_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign outBus = output_sel ? a_q[N-1:0] : q_q;

endmodule

`default_nettype wire
